// File: rtl/debug_dcsr_ctrl.sv
// Debug-mode control: dcsr/dpc ownership, entry-cause arbitration, single-step and dret sequencing.
// Optional macro DCSR_STEPIE_EN makes dcsr.stepie (bit 11) writable and lets it unmask interrupts while stepping.
module debug_dcsr_ctrl #(
  parameter bit          HAS_UMODE = 1'b1,
  parameter bit          HAS_SMODE = 1'b0,
  parameter int unsigned PC_W      = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      cur_prv,
  input  logic [PC_W-1:0] entry_pc,
  input  logic            trigger_hit,
  input  logic            ebreak_ret,
  input  logic            halt_req,
  input  logic            resethalt_req,
  input  logic            insn_retire,
  input  logic            dret,
  input  logic            csr_wr_en,
  input  logic [31:0]     csr_wr_data,
  output logic [31:0]     csr_rd_data,
  output logic [PC_W-1:0] dpc,
  output logic            debug_mode,
  output logic            enter_pulse,
  output logic            exit_pulse,
  output logic [1:0]      restore_prv,
  output logic            ebreak_to_dm,
  output logic            irq_mask,
  output logic [1:0]      dcsr_prv,
  output logic            dcsr_step,
  output logic [2:0]      dcsr_cause,
  output logic            dcsr_stoptime,
  output logic            dcsr_stopcycle,
  output logic            dcsr_ebreaku,
  output logic            dcsr_ebreaks,
  output logic            dcsr_ebreakm,
  output logic [1:0]      dcsr_xdebugver
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STEP   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
  localparam logic [2:0] CAUSE_TRIGGER   = 3'd2;
  localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
  localparam logic [2:0] CAUSE_STEP      = 3'd4;
  localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

  logic [1:0] state, state_nxt;
  logic       first_cycle;
  logic [1:0] prv_q;
  logic       step_q;
  logic [2:0] cause_q;
  logic       stoptime_q, stopcycle_q;
  logic       ebreaku_q, ebreaks_q, ebreakm_q;
  logic       stepie_q;

  logic       accept;
  logic       entry_valid;
  logic [2:0] entry_cause;
  logic       wr_ok;
  logic       prv_wr_legal;
  logic       unused_wr;

  assign unused_wr = ^{csr_wr_data[31:16], csr_wr_data[14], csr_wr_data[8:3]};

  always_comb begin
    ebreak_to_dm = 1'b0;
    case (cur_prv)
      2'd3:    ebreak_to_dm = ebreak_ret & ebreakm_q;
      2'd1:    ebreak_to_dm = ebreak_ret & ebreaks_q;
      2'd0:    ebreak_to_dm = ebreak_ret & ebreaku_q;
      default: ebreak_to_dm = 1'b0;
    endcase
  end

  assign accept = (state == ST_RUN) || (state == ST_STEP);

  // Fixed priority: trigger > ebreak > resethalt > haltreq > step.
  always_comb begin
    entry_valid = 1'b0;
    entry_cause = '0;
    if (accept) begin
      if (trigger_hit) begin
        entry_valid = 1'b1;
        entry_cause = CAUSE_TRIGGER;
      end else if (ebreak_to_dm) begin
        entry_valid = 1'b1;
        entry_cause = CAUSE_EBREAK;
      end else if (first_cycle && resethalt_req) begin
        entry_valid = 1'b1;
        entry_cause = CAUSE_RESETHALT;
      end else if (halt_req) begin
        entry_valid = 1'b1;
        entry_cause = CAUSE_HALTREQ;
      end else if ((state == ST_STEP) && insn_retire) begin
        entry_valid = 1'b1;
        entry_cause = CAUSE_STEP;
      end
    end
  end

  assign exit_pulse  = (state == ST_HALTED) && dret;
  assign restore_prv = prv_q;
  assign wr_ok       = (state == ST_HALTED) && csr_wr_en && !dret;

  always_comb begin
    prv_wr_legal = 1'b0;
    case (csr_wr_data[1:0])
      2'd3:    prv_wr_legal = 1'b1;
      2'd1:    prv_wr_legal = HAS_SMODE;
      2'd0:    prv_wr_legal = HAS_UMODE;
      default: prv_wr_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN, ST_STEP: if (entry_valid) state_nxt = ST_HALTED;
      ST_HALTED:       if (dret) state_nxt = step_q ? ST_STEP : ST_RUN;
      default:         state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      first_cycle <= 1'b1;
      prv_q       <= 2'd3;
      step_q      <= 1'b0;
      cause_q     <= '0;
      stoptime_q  <= 1'b0;
      stopcycle_q <= 1'b0;
      ebreaku_q   <= 1'b0;
      ebreaks_q   <= 1'b0;
      ebreakm_q   <= 1'b0;
      dpc         <= '0;
      enter_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      first_cycle <= 1'b0;
      enter_pulse <= entry_valid;
      if (entry_valid) begin
        cause_q <= entry_cause;
        prv_q   <= cur_prv;
        dpc     <= entry_pc;
      end else if (wr_ok) begin
        step_q      <= csr_wr_data[2];
        stoptime_q  <= csr_wr_data[9];
        stopcycle_q <= csr_wr_data[10];
        ebreaku_q   <= HAS_UMODE & csr_wr_data[12];
        ebreaks_q   <= HAS_SMODE & csr_wr_data[13];
        ebreakm_q   <= csr_wr_data[15];
        if (prv_wr_legal) prv_q <= csr_wr_data[1:0];
      end
    end
  end

`ifdef DCSR_STEPIE_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stepie_q <= 1'b0;
    else if (wr_ok) stepie_q <= csr_wr_data[11];
  end
  assign irq_mask = (state == ST_STEP) && !stepie_q;
`else
  logic unused_stepie_wr;
  assign unused_stepie_wr = csr_wr_data[11];
  assign stepie_q         = 1'b0;
  assign irq_mask         = (state == ST_STEP);
`endif

  assign debug_mode = (state == ST_HALTED);

  always_comb begin
    csr_rd_data        = '0;
    csr_rd_data[31:28] = 4'd4;
    csr_rd_data[15]    = ebreakm_q;
    csr_rd_data[13]    = ebreaks_q;
    csr_rd_data[12]    = ebreaku_q;
    csr_rd_data[11]    = stepie_q;
    csr_rd_data[10]    = stopcycle_q;
    csr_rd_data[9]     = stoptime_q;
    csr_rd_data[8:6]   = cause_q;
    csr_rd_data[2]     = step_q;
    csr_rd_data[1:0]   = prv_q;
  end

  assign dcsr_prv       = prv_q;
  assign dcsr_step      = step_q;
  assign dcsr_cause     = cause_q;
  assign dcsr_stoptime  = stoptime_q;
  assign dcsr_stopcycle = stopcycle_q;
  assign dcsr_ebreaku   = ebreaku_q;
  assign dcsr_ebreaks   = ebreaks_q;
  assign dcsr_ebreakm   = ebreakm_q;
  assign dcsr_xdebugver = 2'b00;

endmodule

// File: tb/tb_debug_dcsr_ctrl.sv
// Bench for debug_dcsr_ctrl: a rule-level model checked every negedge plus directed literal expectations.
module tb_debug_dcsr_ctrl;

  localparam bit          UMODE = 1'b1;
  localparam bit          SMODE = 1'b0;
  localparam int unsigned PCW   = 32;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [1:0]      cur_prv;
  logic [PCW-1:0]  entry_pc;
  logic            trigger_hit, ebreak_ret, halt_req, resethalt_req, insn_retire, dret, csr_wr_en;
  logic [31:0]     csr_wr_data;
  logic [31:0]     csr_rd_data;
  logic [PCW-1:0]  dpc;
  logic            debug_mode, enter_pulse, exit_pulse, ebreak_to_dm, irq_mask;
  logic [1:0]      restore_prv, dcsr_prv, dcsr_xdebugver;
  logic            dcsr_step, dcsr_stoptime, dcsr_stopcycle, dcsr_ebreaku, dcsr_ebreaks, dcsr_ebreakm;
  logic [2:0]      dcsr_cause;

  int vectors    = 0;
  int miscompares = 0;
  bit armed      = 1'b0;

  debug_dcsr_ctrl #(.HAS_UMODE(UMODE), .HAS_SMODE(SMODE), .PC_W(PCW)) dut (
    .clock(clock), .reset_n(reset_n), .cur_prv(cur_prv), .entry_pc(entry_pc),
    .trigger_hit(trigger_hit), .ebreak_ret(ebreak_ret), .halt_req(halt_req),
    .resethalt_req(resethalt_req), .insn_retire(insn_retire), .dret(dret),
    .csr_wr_en(csr_wr_en), .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
    .dpc(dpc), .debug_mode(debug_mode), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
    .restore_prv(restore_prv), .ebreak_to_dm(ebreak_to_dm), .irq_mask(irq_mask),
    .dcsr_prv(dcsr_prv), .dcsr_step(dcsr_step), .dcsr_cause(dcsr_cause),
    .dcsr_stoptime(dcsr_stoptime), .dcsr_stopcycle(dcsr_stopcycle),
    .dcsr_ebreaku(dcsr_ebreaku), .dcsr_ebreaks(dcsr_ebreaks), .dcsr_ebreakm(dcsr_ebreakm),
    .dcsr_xdebugver(dcsr_xdebugver)
  );

  always #5 clock = ~clock;

  // Model: the hart is either halted or not; a running hart may be stepping.
  bit         m_halted, m_stepping, m_first, m_enter;
  bit         m_step, m_stoptime, m_stopcycle, m_ebu, m_ebs, m_ebm, m_stepie;
  int         m_prv, m_cause;
  logic [PCW-1:0] m_dpc;

  function automatic bit m_ebreak_hit();
    bit en[4];
    en[0] = m_ebu; en[1] = m_ebs; en[2] = 1'b0; en[3] = m_ebm;
    return ebreak_ret && en[cur_prv];
  endfunction

  function automatic int m_winner();
    bit hit[8];
    int order[5];
    order = '{2, 1, 5, 3, 4};
    foreach (hit[k]) hit[k] = 1'b0;
    hit[2] = trigger_hit;
    hit[1] = m_ebreak_hit();
    hit[5] = m_first && resethalt_req;
    hit[3] = halt_req;
    hit[4] = m_stepping && insn_retire;
    for (int i = 0; i < 5; i++) if (hit[order[i]]) return order[i];
    return 0;
  endfunction

  function automatic bit m_prv_legal(input int p);
    return (p == 3) || (p == 0 && UMODE) || (p == 1 && SMODE);
  endfunction

  function automatic logic [31:0] m_read();
    return 32'(4 * (2 ** 28) + m_ebm * (2 ** 15) + m_ebs * (2 ** 13) + m_ebu * (2 ** 12)
              + m_stepie * (2 ** 11) + m_stopcycle * (2 ** 10) + m_stoptime * (2 ** 9)
              + m_cause * 64 + m_step * 4 + m_prv);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_halted <= 1'b0; m_stepping <= 1'b0; m_first <= 1'b1; m_enter <= 1'b0;
      m_step <= 1'b0; m_stoptime <= 1'b0; m_stopcycle <= 1'b0;
      m_ebu <= 1'b0; m_ebs <= 1'b0; m_ebm <= 1'b0; m_stepie <= 1'b0;
      m_prv <= 3; m_cause <= 0; m_dpc <= '0;
    end else begin
      m_first <= 1'b0;
      m_enter <= 1'b0;
      if (!m_halted) begin
        if (m_winner() != 0) begin
          m_halted <= 1'b1; m_stepping <= 1'b0; m_enter <= 1'b1;
          m_cause <= m_winner(); m_prv <= int'(cur_prv); m_dpc <= entry_pc;
        end
      end else if (dret) begin
        m_halted <= 1'b0;
        m_stepping <= m_step;
      end else if (csr_wr_en) begin
        m_step <= csr_wr_data[2];
        m_stoptime <= csr_wr_data[9];
        m_stopcycle <= csr_wr_data[10];
        m_ebu <= UMODE && csr_wr_data[12];
        m_ebs <= SMODE && csr_wr_data[13];
        m_ebm <= csr_wr_data[15];
`ifdef DCSR_STEPIE_EN
        m_stepie <= csr_wr_data[11];
`endif
        if (m_prv_legal(int'(csr_wr_data[1:0]))) m_prv <= int'(csr_wr_data[1:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (armed) begin
      chk("m_csr", csr_rd_data, m_read());
      chk("m_dpc", dpc, m_dpc);
      chk("m_debug_mode", debug_mode, m_halted);
      chk("m_enter", enter_pulse, m_enter);
      chk("m_exit", exit_pulse, m_halted && dret);
      if (m_halted && dret) chk("m_restore_prv", restore_prv, 64'(m_prv));
      chk("m_ebreak_to_dm", ebreak_to_dm, m_ebreak_hit());
      chk("m_irq_mask", irq_mask, !m_halted && m_stepping && !m_stepie);
      chk("m_taps", {dcsr_prv, dcsr_step, dcsr_cause, dcsr_stoptime, dcsr_stopcycle,
                     dcsr_ebreaku, dcsr_ebreaks, dcsr_ebreakm, dcsr_xdebugver},
          {2'(m_prv), m_step, 3'(m_cause), m_stoptime, m_stopcycle, m_ebu, m_ebs, m_ebm, 2'b00});
    end
  end

  task automatic clr();
    trigger_hit = 0; ebreak_ret = 0; halt_req = 0; resethalt_req = 0;
    insn_retire = 0; dret = 0; csr_wr_en = 0; csr_wr_data = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic csr_write(input logic [31:0] d);
    csr_wr_en = 1; csr_wr_data = d;
    tick();
    csr_wr_en = 0; csr_wr_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    clr();
    cur_prv = 2'd3; entry_pc = 32'h80; resethalt_req = 1;
    reset_n = 1; #1 reset_n = 0; #1 armed = 1;
    tick(); tick();
    chk("rst_csr", csr_rd_data, 32'h4000_0003);
    chk("rst_debug_mode", debug_mode, 0);
    chk("rst_dpc", dpc, 0);
    chk("rst_enter", enter_pulse, 0);
    reset_n = 1;
    tick();
    chk("rh_debug_mode", debug_mode, 1);
    chk("rh_cause", dcsr_cause, 5);
    chk("rh_dpc", dpc, 32'h80);
    chk("rh_enter", enter_pulse, 1);
    resethalt_req = 0;
    tick();
    chk("rh_enter_once", enter_pulse, 0);

    csr_write(32'h0000_8003);
    chk("wr_ebreakm", csr_rd_data, 32'h4000_8143);
    dret = 1; #1;
    chk("dret1_exit", exit_pulse, 1);
    chk("dret1_rprv", restore_prv, 3);
    tick(); dret = 0;
    chk("run_debug_mode", debug_mode, 0);

    trigger_hit = 1; ebreak_ret = 1; halt_req = 1; cur_prv = 2'd3; entry_pc = 32'h200; #1;
    chk("multi_ebk_dm", ebreak_to_dm, 1);
    tick(); trigger_hit = 0; ebreak_ret = 0;
    chk("multi_cause", dcsr_cause, 2);
    chk("multi_enter", enter_pulse, 1);
    chk("multi_dpc", dpc, 32'h200);
    tick();
    chk("multi_enter_once", enter_pulse, 0);
    tick(); halt_req = 0;
    chk("halted_hold_cause", dcsr_cause, 2);

    csr_write(32'h0000_0004);
    chk("wr_step", csr_rd_data, 32'h4000_0084);
    dret = 1; #1;
    chk("dret2_rprv", restore_prv, 0);
    tick(); dret = 0;
    chk("step_debug_mode", debug_mode, 0);
    chk("step_irq_mask", irq_mask, 1);
    tick();
    chk("step_idle", debug_mode, 0);
    insn_retire = 1; entry_pc = 32'h104; cur_prv = 2'd0;
    tick(); insn_retire = 0;
    chk("step_cause", dcsr_cause, 4);
    chk("step_dpc", dpc, 32'h104);
    chk("step_prv", dcsr_prv, 0);

    csr_write(32'h0000_0005);
    chk("warl_prv1", csr_rd_data, 32'h4000_0104);
    csr_write(32'hFFFF_FFFF);
    chk("wr_all_ones", csr_rd_data, 32'h4000_9707);
    csr_write(32'h0000_0002);
    chk("warl_prv2", csr_rd_data, 32'h4000_0103);
    csr_write(32'h0000_0000);
    chk("wr_zero", csr_rd_data, 32'h4000_0100);
    dret = 1; tick(); dret = 0;
    chk("run2_irq_mask", irq_mask, 0);
    csr_write(32'hFFFF_FFFF);
    chk("wr_in_run", csr_rd_data, 32'h4000_0100);

    ebreak_ret = 1; cur_prv = 2'd0; #1;
    chk("ebku0_dm", ebreak_to_dm, 0);
    tick(); ebreak_ret = 0;
    chk("ebku0_no_entry", debug_mode, 0);
    halt_req = 1; tick(); halt_req = 0;
    chk("halt_cause", dcsr_cause, 3);
    csr_write(32'h0000_1000);
    chk("wr_ebreaku", csr_rd_data, 32'h4000_10C0);
    dret = 1; tick(); dret = 0;
    ebreak_ret = 1; #1;
    chk("ebku1_dm", ebreak_to_dm, 1);
    tick(); ebreak_ret = 0;
    chk("ebku1_cause", dcsr_cause, 1);
    chk("ebku1_debug_mode", debug_mode, 1);

    csr_wr_en = 1; csr_wr_data = 32'hFFFF_FFFF; dret = 1; #1;
    chk("wr_dret_exit", exit_pulse, 1);
    tick(); clr();
    chk("wr_dret_dropped", csr_rd_data, 32'h4000_1040);
    chk("wr_dret_run", debug_mode, 0);
    halt_req = 1; tick(); clr();
    csr_write(32'h0000_1004);
    dret = 1; tick(); dret = 0;
    chk("step2_irq_mask", irq_mask, 1);
    halt_req = 1; insn_retire = 1; tick(); clr();
    chk("halt_beats_step", csr_rd_data, 32'h4000_10C4);
    dret = 1; tick(); dret = 0;
    chk("step3_debug_mode", debug_mode, 0);
    #2 reset_n = 0; #1;
    chk("arst_irq_mask", irq_mask, 0);
    chk("arst_csr", csr_rd_data, 32'h4000_0003);
    chk("arst_dpc", dpc, 0);
    chk("arst_debug_mode", debug_mode, 0);
    tick(); reset_n = 1;
    tick(); tick();
    chk("post_rst_run", debug_mode, 0);

    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
